// File: rtl/ss_frame_rx_if.sv
// Output frame bus of ss_frame_rx: decoded value, per-digit error flags, valid/ready and overrun.
// SS_DP_EN adds the decimal-point frame dp_out.
interface ss_frame_rx_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_err;
  logic                out_valid;
  logic                out_ready;
  logic                overrun;
`ifdef SS_DP_EN
  logic [DIGITS-1:0]   dp_out;

  modport master (output value, digit_err, out_valid, overrun, dp_out, input out_ready);
  modport slave  (input value, digit_err, out_valid, overrun, dp_out, output out_ready);
`else
  modport master (output value, digit_err, out_valid, overrun, input out_ready);
  modport slave  (input value, digit_err, out_valid, overrun, output out_ready);
`endif
endinterface

// File: rtl/ss_frame_rx.sv
// Seven-segment bus receiver: synchronizes, qualifies each digit dwell, decodes glyphs into a frame.
// Optional macro SS_DP_EN adds the decimal-point input seg_dp_n and output frame dp_out.
module ss_frame_rx #(
  parameter int DIGITS      = 4,
  parameter int STABLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg_n,
  input  logic [DIGITS-1:0] dig_sel,
`ifdef SS_DP_EN
  input  logic              seg_dp_n,
`endif
  ss_frame_rx_if.master     out_if
);

`ifdef SS_DP_EN
  localparam int DP_W = 1;
`else
  localparam int DP_W = 0;
`endif
  localparam int SW    = DP_W + 7 + DIGITS;
  localparam int CNT_W = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
`ifdef SS_DP_EN
  localparam logic [SW-1:0] SYNC_RST = {1'b1, 7'h7F, {DIGITS{1'b0}}};
`else
  localparam logic [SW-1:0] SYNC_RST = {7'h7F, {DIGITS{1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, DWELL, HELD} state_e;

  // Returns {err, nibble}; anything outside the sixteen glyphs decodes to 0 with err set.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40: r = 5'h00;
      7'h79: r = 5'h01;
      7'h24: r = 5'h02;
      7'h30: r = 5'h03;
      7'h19: r = 5'h04;
      7'h12: r = 5'h05;
      7'h02: r = 5'h06;
      7'h78: r = 5'h07;
      7'h00: r = 5'h08;
      7'h10: r = 5'h09;
      7'h08: r = 5'h0A;
      7'h03: r = 5'h0B;
      7'h46: r = 5'h0C;
      7'h21: r = 5'h0D;
      7'h06: r = 5'h0E;
      7'h0E: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [SW-1:0] raw_in;
`ifdef SS_DP_EN
  assign raw_in = {seg_dp_n, seg_n, dig_sel};
`else
  assign raw_in = {seg_n, dig_sel};
`endif

  logic [SW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= SYNC_RST;
    end else begin
      sync_q[0] <= raw_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  logic [SW-1:0]       cur;
  logic [6:0]          seg_s;
  logic [DIGITS-1:0]   dig_s;
  logic [SW-1:0]       prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_e              state_q;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] shadow_q, value_q;
  logic [DIGITS-1:0]   shadow_err_q, err_q;
  logic                load_q, valid_q, overrun_q;
  logic                same, onehot, capture;
  logic [4:0]          dec;
`ifdef SS_DP_EN
  logic                dp_s;
  logic [DIGITS-1:0]   shadow_dp_q, dp_q;
`endif

  always_comb begin
    cur     = sync_q[SYNC_STAGES-1];
    seg_s   = cur[DIGITS +: 7];
    dig_s   = cur[DIGITS-1:0];
    same    = (cur == prev_q);
    onehot  = (dig_s != '0) && ((dig_s & (dig_s - 1'b1)) == '0);
    cnt_d   = '0;
    if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    capture = (state_q == DWELL) && same && onehot && (cnt_q == CNT_MAX);
    seen_d  = seen_q | dig_s;
    dec     = decode(seg_s);
  end

`ifdef SS_DP_EN
  assign dp_s = cur[SW-1];
`endif

  // The capture edge fills the shadow slot; the frame moves to the outputs one edge later via load_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= SYNC_RST;
      cnt_q        <= '0;
      seen_q       <= '0;
      shadow_q     <= '0;
      shadow_err_q <= '0;
      load_q       <= 1'b0;
      value_q      <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef SS_DP_EN
      shadow_dp_q  <= '0;
      dp_q         <= '0;
`endif
    end else begin
      prev_q    <= cur;
      cnt_q     <= cnt_d;
      overrun_q <= 1'b0;
      load_q    <= capture && (&seen_d);

      case (state_q)
        IDLE:    if (onehot) state_q <= DWELL;
        DWELL: begin
          if (!onehot)      state_q <= IDLE;
          else if (capture) state_q <= HELD;
        end
        HELD:    if (!same) state_q <= onehot ? DWELL : IDLE;
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_s[i]) begin
            shadow_q[4*i +: 4] <= dec[3:0];
            shadow_err_q[i]    <= dec[4];
`ifdef SS_DP_EN
            shadow_dp_q[i]     <= ~dp_s;
`endif
          end
        end
        seen_q <= seen_d;
      end

      if (load_q) begin
        seen_q <= '0;
        if (valid_q && !out_if.out_ready) begin
          overrun_q <= 1'b1;
        end else begin
          value_q <= shadow_q;
          err_q   <= shadow_err_q;
          valid_q <= 1'b1;
`ifdef SS_DP_EN
          dp_q    <= shadow_dp_q;
`endif
        end
      end else if (valid_q && out_if.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_if.value     = value_q;
  assign out_if.digit_err = err_q;
  assign out_if.out_valid = valid_q;
  assign out_if.overrun   = overrun_q;
`ifdef SS_DP_EN
  assign out_if.dp_out    = dp_q;
`endif

endmodule

// File: tb/tb_ss_frame_rx.sv
// Scoreboard bench for ss_frame_rx: directed digit sequences push expected frames, a monitor checks transfers.
module tb_ss_frame_rx;
  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_sel;
`ifdef SS_DP_EN
  logic        seg_dp_n = 1'b1;
`endif

  ss_frame_rx_if #(.DIGITS(DIGITS)) bus ();

  ss_frame_rx #(.DIGITS(DIGITS), .STABLE_CYC(8), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_n   (seg_n),
    .dig_sel (dig_sel),
`ifdef SS_DP_EN
    .seg_dp_n(seg_dp_n),
`endif
    .out_if  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] v;
    logic [3:0]  e;
  } frame_t;

  frame_t expQ[$];
  int     total = 0;
  int     bad = 0;
  int     overrunCount = 0;
  bit     validSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expected frame on every completed transfer.
  always @(negedge clk) begin
    frame_t f;
    if (rst_n === 1'b1) begin
      if (bus.overrun === 1'b1) overrunCount++;
      if (bus.out_valid === 1'b1) validSeen = 1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected frame", 32'(bus.value), 32'hFFFF_FFFF);
        end else begin
          f = expQ.pop_front();
          checkOutput("frame value", 32'(bus.value), 32'(f.v));
          checkOutput("frame digit_err", 32'(bus.digit_err), 32'(f.e));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] d, input logic [6:0] s, input int cyc);
    dig_sel = d;
    seg_n   = s;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [27:0] segs);
    for (int i = 0; i < 4; i++) applyStimulus(4'(1 << i), segs[7*i +: 7], 20);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " value"}, 32'(bus.value), 32'h0);
    checkOutput({tag, " digit_err"}, 32'(bus.digit_err), 32'h0);
    checkOutput({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    checkOutput({tag, " overrun"}, 32'(bus.overrun), 32'h0);
  endtask

  initial begin
    int ovBase;
    int waitCyc;
    rst_n         = 1'b0;
    seg_n         = 7'h7F;
    dig_sel       = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic frame 4321");
    expQ.push_back('{v: 16'h4321, e: 4'h0});
    sendFrame({7'h19, 7'h30, 7'h24, 7'h79});

    $display("[TB] unstable digit 0 must not be captured");
    validSeen = 0;
    for (int k = 0; k < 12; k++) applyStimulus(4'b0001, k[0] ? 7'h24 : 7'h79, 5);
    applyStimulus(4'b0010, 7'h24, 20);
    applyStimulus(4'b0100, 7'h30, 20);
    applyStimulus(4'b1000, 7'h19, 20);
    checkOutput("no frame from toggling digit", 32'(validSeen), 32'h0);
    expQ.push_back('{v: 16'h4321, e: 4'h0});
    applyStimulus(4'b0001, 7'h79, 20);

    $display("[TB] illegal glyph on digit 2");
    expQ.push_back('{v: 16'h0000, e: 4'b0100});
    sendFrame({7'h40, 7'h7F, 7'h40, 7'h40});

    $display("[TB] backpressure and overrun");
    bus.out_ready = 1'b0;
    ovBase = overrunCount;
    expQ.push_back('{v: 16'h4321, e: 4'h0});
    sendFrame({7'h19, 7'h30, 7'h24, 7'h79});
    sendFrame({7'h00, 7'h78, 7'h02, 7'h12});
    @(negedge clk);
    checkOutput("held value under backpressure", 32'(bus.value), 32'h4321);
    checkOutput("held out_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("overrun pulses", 32'(overrunCount - ovBase), 32'h1);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("out_valid drops after transfer", 32'(bus.out_valid), 32'h0);
    checkOutput("held frame drained", 32'(expQ.size()), 32'h0);

    $display("[TB] two-hot select and digit overwrite");
    @(posedge clk);
    #1;
    applyStimulus(4'b0011, 7'h79, 50);
    validSeen = 0;
    expQ.push_back('{v: 16'h4326, e: 4'h0});
    applyStimulus(4'b0001, 7'h79, 20);
    applyStimulus(4'b0001, 7'h02, 20);
    applyStimulus(4'b0100, 7'h30, 20);
    applyStimulus(4'b1000, 7'h19, 20);
    checkOutput("no early frame after two-hot", 32'(validSeen), 32'h0);
    applyStimulus(4'b0010, 7'h24, 20);

    $display("[TB] reset mid-dwell");
    applyStimulus(4'b0001, 7'h79, 20);
    applyStimulus(4'b0010, 7'h24, 20);
    applyStimulus(4'b0100, 7'h30, 20);
    applyStimulus(4'b1000, 7'h19, 5);
    rst_n = 1'b0;
    #1;
    checkIdleOutputs("mid-dwell reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    validSeen = 0;
    applyStimulus(4'b1000, 7'h19, 20);
    checkOutput("partial frame lost", 32'(validSeen), 32'h0);
    expQ.push_back('{v: 16'h4321, e: 4'h0});
    sendFrame({7'h19, 7'h30, 7'h24, 7'h79});

    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 200) begin
      @(posedge clk);
      waitCyc++;
    end
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
